// File: rtl/meas_pkg.sv
// Shared definitions for the measurement sequencer: FSM state encoding and
// the host command bytes.
package meas_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_HDR     = 3'd1,
        ST_DA_RUN  = 3'd2,
        ST_CAPTURE = 3'd3,
        ST_DUMP    = 3'd4
    } state_t;

    localparam logic [7:0] HDR_BYTE  = 8'hA5;
    localparam logic [7:0] CMD_1M    = 8'h01;
    localparam logic [7:0] CMD_5M    = 8'h02;
    localparam logic [7:0] CMD_ABORT = 8'hFF;

    // Largest of four interval lengths; sizes the shared counter.
    function automatic int max4(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage

// File: rtl/seq_timer.sv
// Up-counter with synchronous clear, saturation at all-ones and a terminal
// count compare against a per-state load value.
module seq_timer #(
    parameter int W = 8
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_clear,
    input  logic [W-1:0] i_tc,
    output logic         o_tc_hit
);

    logic [W-1:0] r_cnt;

    // Count up from zero after each clear; hold at all-ones instead of wrapping.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            r_cnt <= '0;
        else if (i_clear)
            r_cnt <= '0;
        else if (r_cnt != '1)
            r_cnt <= r_cnt + 1'b1;
    end

    assign o_tc_hit = (r_cnt == i_tc);

endmodule

// File: rtl/meas_seq_ctrl.sv
// Measurement command sequencer: parses header+command frames from the UART
// receiver and runs DA -> settle -> AD capture -> UART dump, with timeouts
// and a host abort.
//
// state      | meaning
// -----------+------------------------------------------------------
// IDLE   (0) | waiting for header byte
// HDR    (1) | header seen, waiting for command byte (timeout)
// DA_RUN (2) | DA running, settle interval before capture
// CAPTURE(3) | DA + AD running, waiting for cap_done (timeout)
// DUMP   (4) | UART dump of sample RAM, waiting for tx_done (timeout)
module meas_seq_ctrl
    import meas_pkg::*;
#(
    parameter int CLK_FREQ   = 50000000,
    parameter int SETTLE_CYC = 500,
    parameter int HDR_TO_CYC = 5000000,
    parameter int CAP_TO_CYC = 1000000,
    parameter int TX_TO_CYC  = 50000000
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic [7:0] rx_data,
    input  logic       rx_done,
    input  logic       cap_done,
    input  logic       tx_done,
    output logic       da_en,
    output logic       da_sel,
    output logic       ad_en,
    output logic       tx_en,
    output logic       busy,
    output logic       err_to,
    output logic [2:0] state_dbg
);

    localparam int CNT_MAX = max4(SETTLE_CYC, HDR_TO_CYC, CAP_TO_CYC, TX_TO_CYC);
    localparam int CNT_W   = $clog2(CNT_MAX) + 1;

    // A zero settle interval or clock frequency would make the intervals meaningless.
    if (SETTLE_CYC < 1 || CLK_FREQ < 1) begin : g_bad_param
        $error("meas_seq_ctrl: SETTLE_CYC and CLK_FREQ must be >= 1");
    end

    state_t           r_state;
    logic             r_da_en, r_da_sel, r_ad_en, r_tx_en, r_busy, r_err_to;
    logic [CNT_W-1:0] w_tc_val;
    logic             w_tc, w_leave, w_clear;
    logic             w_rx_hdr, w_rx_cmd, w_rx_abort;

    assign w_rx_hdr   = rx_done && (rx_data == HDR_BYTE);
    assign w_rx_cmd   = rx_done && ((rx_data == CMD_1M) || (rx_data == CMD_5M));
    assign w_rx_abort = rx_done && (rx_data == CMD_ABORT);

    // Terminal count for the interval belonging to the current state.
    always_comb begin
        w_tc_val = '0;
        case (r_state)
            ST_HDR:     w_tc_val = CNT_W'(HDR_TO_CYC - 1);
            ST_DA_RUN:  w_tc_val = CNT_W'(SETTLE_CYC - 1);
            ST_CAPTURE: w_tc_val = CNT_W'(CAP_TO_CYC - 1);
            ST_DUMP:    w_tc_val = CNT_W'(TX_TO_CYC - 1);
            default:    w_tc_val = '0;
        endcase
    end

    // Any event that moves the FSM restarts the counter; it is also held at zero in IDLE.
    always_comb begin
        w_leave = 1'b0;
        case (r_state)
            ST_IDLE:    w_leave = w_rx_hdr;
            ST_HDR:     w_leave = rx_done || w_tc;
            ST_DA_RUN:  w_leave = w_rx_abort || w_tc;
            ST_CAPTURE: w_leave = w_rx_abort || cap_done || w_tc;
            ST_DUMP:    w_leave = w_rx_abort || tx_done || w_tc;
            default:    w_leave = 1'b1;
        endcase
    end

    assign w_clear = w_leave || (r_state == ST_IDLE);

    seq_timer #(.W(CNT_W)) u_timer (
        .i_clk    (sys_clk),
        .i_rst_n  (sys_rst_n),
        .i_clear  (w_clear),
        .i_tc     (w_tc_val),
        .o_tc_hit (w_tc)
    );

    // Sequencer FSM with registered outputs; abort outranks success, success outranks timeout.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_state  <= ST_IDLE;
            r_da_en  <= 1'b0;
            r_da_sel <= 1'b0;
            r_ad_en  <= 1'b0;
            r_tx_en  <= 1'b0;
            r_busy   <= 1'b0;
            r_err_to <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_rx_hdr)
                        r_state <= ST_HDR;
                end
                ST_HDR: begin
                    if (w_rx_cmd) begin
                        r_state  <= ST_DA_RUN;
                        r_da_en  <= 1'b1;
                        r_busy   <= 1'b1;
                        r_da_sel <= (rx_data == CMD_5M);
                        r_err_to <= 1'b0;
                    end else if (rx_done) begin
                        r_state <= ST_IDLE;
                    end else if (w_tc) begin
                        r_state  <= ST_IDLE;
                        r_err_to <= 1'b1;
                    end
                end
                ST_DA_RUN: begin
                    if (w_rx_abort) begin
                        r_state <= ST_IDLE;
                        r_da_en <= 1'b0;
                        r_busy  <= 1'b0;
                    end else if (w_tc) begin
                        r_state <= ST_CAPTURE;
                        r_ad_en <= 1'b1;
                    end
                end
                ST_CAPTURE: begin
                    if (w_rx_abort || (w_tc && !cap_done)) begin
                        r_state <= ST_IDLE;
                        r_da_en <= 1'b0;
                        r_ad_en <= 1'b0;
                        r_busy  <= 1'b0;
                        if (!w_rx_abort)
                            r_err_to <= 1'b1;
                    end else if (cap_done) begin
                        r_state <= ST_DUMP;
                        r_da_en <= 1'b0;
                        r_ad_en <= 1'b0;
                        r_tx_en <= 1'b1;
                    end
                end
                ST_DUMP: begin
                    if (w_rx_abort || tx_done || w_tc) begin
                        r_state <= ST_IDLE;
                        r_tx_en <= 1'b0;
                        r_busy  <= 1'b0;
                        if (!w_rx_abort && !tx_done)
                            r_err_to <= 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_da_en <= 1'b0;
                    r_ad_en <= 1'b0;
                    r_tx_en <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign da_en     = r_da_en;
    assign da_sel    = r_da_sel;
    assign ad_en     = r_ad_en;
    assign tx_en     = r_tx_en;
    assign busy      = r_busy;
    assign err_to    = r_err_to;
    assign state_dbg = r_state;

endmodule

// File: tb/tb_meas_seq_ctrl.sv
// Directed bench for meas_seq_ctrl with short intervals:
// SETTLE=4, HDR_TO=20, CAP_TO=50, TX_TO=50.
module tb_meas_seq_ctrl;
    import meas_pkg::*;

    logic       sys_clk = 1'b0;
    logic       sys_rst_n = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       rx_done = 1'b0;
    logic       cap_done = 1'b0;
    logic       tx_done = 1'b0;
    logic       da_en, da_sel, ad_en, tx_en, busy, err_to;
    logic [2:0] state_dbg;

    int checks = 0;
    int failures = 0;

    meas_seq_ctrl #(
        .CLK_FREQ   (50000000),
        .SETTLE_CYC (4),
        .HDR_TO_CYC (20),
        .CAP_TO_CYC (50),
        .TX_TO_CYC  (50)
    ) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .rx_data   (rx_data),
        .rx_done   (rx_done),
        .cap_done  (cap_done),
        .tx_done   (tx_done),
        .da_en     (da_en),
        .da_sel    (da_sel),
        .ad_en     (ad_en),
        .tx_en     (tx_en),
        .busy      (busy),
        .err_to    (err_to),
        .state_dbg (state_dbg)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Packs {state, busy, da_en, da_sel, ad_en, tx_en, err_to} for compact checks.
    function automatic logic [31:0] pk(input logic [2:0] st, input logic b, input logic de,
                                       input logic ds, input logic ae, input logic te,
                                       input logic er);
        return {23'd0, st, b, de, ds, ae, te, er};
    endfunction

    function automatic logic [31:0] obs_all();
        return pk(state_dbg, busy, da_en, da_sel, ad_en, tx_en, err_to);
    endfunction

    // One-cycle strobe on rx_done; returns at the falling edge after the sampling edge.
    task automatic send(input logic [7:0] b);
        rx_data = b;
        rx_done = 1'b1;
        @(negedge sys_clk);
        rx_done = 1'b0;
        rx_data = 8'h00;
    endtask

    task automatic pulse_cap();
        cap_done = 1'b1;
        @(negedge sys_clk);
        cap_done = 1'b0;
    endtask

    task automatic pulse_tx();
        tx_done = 1'b1;
        @(negedge sys_clk);
        tx_done = 1'b0;
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge sys_clk);
    endtask

    initial begin
        wait_cyc(2);
        chk("reset_outputs", obs_all(), pk(3'd0, 0, 0, 0, 0, 0, 0));
        sys_rst_n = 1'b1;
        wait_cyc(2);
        chk("post_reset_idle", obs_all(), pk(3'd0, 0, 0, 0, 0, 0, 0));

        // 1: full 5 MHz measurement
        send(HDR_BYTE);
        chk("s1_hdr", obs_all(), pk(3'd1, 0, 0, 0, 0, 0, 0));
        send(CMD_5M);
        chk("s1_da_start", obs_all(), pk(3'd2, 1, 1, 1, 0, 0, 0));
        wait_cyc(3);
        chk("s1_settle_edge", obs_all(), pk(3'd2, 1, 1, 1, 0, 0, 0));
        wait_cyc(1);
        chk("s1_ad_rise", obs_all(), pk(3'd3, 1, 1, 1, 1, 0, 0));
        wait_cyc(9);
        pulse_cap();
        chk("s1_dump", obs_all(), pk(3'd4, 1, 0, 1, 0, 1, 0));
        wait_cyc(5);
        pulse_tx();
        chk("s1_done", obs_all(), pk(3'd0, 0, 0, 1, 0, 0, 0));

        // 2: header timeout, then a valid command clears err_to
        send(HDR_BYTE);
        wait_cyc(19);
        chk("s2_hdr_before_to", state_dbg, 3'd1);
        wait_cyc(1);
        chk("s2_hdr_timeout", obs_all(), pk(3'd0, 0, 0, 1, 0, 0, 1));
        send(HDR_BYTE);
        send(CMD_1M);
        chk("s2_err_cleared", obs_all(), pk(3'd2, 1, 1, 0, 0, 0, 0));
        send(CMD_ABORT);
        chk("s2_abort_da", obs_all(), pk(3'd0, 0, 0, 0, 0, 0, 0));

        // 3: abort mid-capture, stray cap_done ignored
        send(HDR_BYTE);
        send(CMD_1M);
        wait_cyc(4);
        chk("s3_capture", obs_all(), pk(3'd3, 1, 1, 0, 1, 0, 0));
        wait_cyc(3);
        send(CMD_ABORT);
        chk("s3_abort", obs_all(), pk(3'd0, 0, 0, 0, 0, 0, 0));
        pulse_cap();
        chk("s3_stray_cap", obs_all(), pk(3'd0, 0, 0, 0, 0, 0, 0));

        // 4: frame while busy ignored; unknown command drops back to IDLE
        send(HDR_BYTE);
        send(CMD_1M);
        send(HDR_BYTE);
        send(CMD_5M);
        chk("s4_busy_ignore", obs_all(), pk(3'd2, 1, 1, 0, 0, 0, 0));
        wait_cyc(2);
        chk("s4_capture", obs_all(), pk(3'd3, 1, 1, 0, 1, 0, 0));
        pulse_cap();
        pulse_tx();
        chk("s4_done", obs_all(), pk(3'd0, 0, 0, 0, 0, 0, 0));
        send(HDR_BYTE);
        send(8'h7E);
        chk("s4_bad_cmd", obs_all(), pk(3'd0, 0, 0, 0, 0, 0, 0));

        // 5: capture timeout, then simultaneous cap_done + abort
        send(HDR_BYTE);
        send(CMD_1M);
        wait_cyc(4);
        wait_cyc(49);
        chk("s5_cap_before_to", obs_all(), pk(3'd3, 1, 1, 0, 1, 0, 0));
        wait_cyc(1);
        chk("s5_cap_timeout", obs_all(), pk(3'd0, 0, 0, 0, 0, 0, 1));
        send(HDR_BYTE);
        send(CMD_5M);
        chk("s5_restart", obs_all(), pk(3'd2, 1, 1, 1, 0, 0, 0));
        wait_cyc(4);
        cap_done = 1'b1;
        send(CMD_ABORT);
        cap_done = 1'b0;
        chk("s5_abort_wins", obs_all(), pk(3'd0, 0, 0, 1, 0, 0, 0));
        wait_cyc(1);
        chk("s5_no_tx", tx_en, 1'b0);

        // 6: asynchronous reset mid-dump, then headerless command ignored
        send(HDR_BYTE);
        send(CMD_5M);
        wait_cyc(4);
        pulse_cap();
        chk("s6_dump", obs_all(), pk(3'd4, 1, 0, 1, 0, 1, 0));
        #1 sys_rst_n = 1'b0;
        #1;
        chk("s6_async_reset", obs_all(), pk(3'd0, 0, 0, 0, 0, 0, 0));
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        wait_cyc(1);
        send(CMD_1M);
        chk("s6_cmd_no_hdr", obs_all(), pk(3'd0, 0, 0, 0, 0, 0, 0));
        send(HDR_BYTE);
        chk("s6_hdr_only", obs_all(), pk(3'd1, 0, 0, 0, 0, 0, 0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
